// File: rtl/fighter_sprite_fetch.sv
// Per-pixel sprite fetch for one fighter: box test, mirrored ROM addressing and a 3-stage return path.
// Anim FSM states:  IDLE | pose is not walking    WALK_A | walk, move frame    WALK_B | walk, stand2 frame
module fighter_sprite_fetch #(
  parameter  int SPR_W       = 96,
  parameter  int SPR_H       = 128,
  parameter  int ANIM_FRAMES = 8,
  localparam int ADDR_W      = $clog2(SPR_W * SPR_H)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic [9:0]        fighter_x,
  input  logic [9:0]        fighter_y,
  input  logic [3:0]        fighter_state,
  input  logic              facing_left,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [3:0]        rom_sel,
  input  logic [3:0]        rom_data,
  output logic [3:0]        pix_index,
  output logic [3:0]        pix_sel,
  output logic              pix_opaque
);

  localparam int CNT_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

  typedef enum logic [1:0] {IDLE, WALK_A, WALK_B} anim_t;

  anim_t            anim;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       cur_sel;
  logic [3:0]       new_pose;

  assign new_pose = (fighter_state > 4'd8) ? 4'd0 : fighter_state;

  // cur_sel is the frame-latched select: the pose, with move swapped for stand2 in WALK_B
  always_ff @(posedge Clk) begin
    if (Reset) begin
      anim    <= IDLE;
      cnt     <= '0;
      cur_sel <= 4'd0;
    end else if (frame_start) begin
      if (new_pose != 4'd1) begin
        anim    <= IDLE;
        cnt     <= '0;
        cur_sel <= new_pose;
      end else begin
        case (anim)
          IDLE: begin
            anim    <= WALK_A;
            cnt     <= '0;
            cur_sel <= 4'd1;
          end
          default: begin
            if (cnt == CNT_W'(ANIM_FRAMES - 1)) begin
              cnt     <= '0;
              anim    <= (anim == WALK_A) ? WALK_B : WALK_A;
              cur_sel <= (anim == WALK_A) ? 4'd9 : 4'd1;
            end else begin
              cnt     <= cnt + 1'b1;
              cur_sel <= (anim == WALK_A) ? 4'd1 : 4'd9;
            end
          end
        endcase
      end
    end
  end

  logic [10:0]       x_end, y_end;
  logic              in_box;
  logic [9:0]        dx, dy;
  logic [ADDR_W-1:0] col, addr;

  // 11-bit compares so a sprite near the right/bottom edge clips instead of wrapping
  assign x_end  = {1'b0, fighter_x} + 11'(SPR_W);
  assign y_end  = {1'b0, fighter_y} + 11'(SPR_H);
  assign in_box = (draw_x >= fighter_x) && ({1'b0, draw_x} < x_end) &&
                  (draw_y >= fighter_y) && ({1'b0, draw_y} < y_end);
  assign dx     = draw_x - fighter_x;
  assign dy     = draw_y - fighter_y;
  assign col    = facing_left ? (ADDR_W'(SPR_W - 1) - ADDR_W'(dx)) : ADDR_W'(dx);
  assign addr   = ADDR_W'(dy) * ADDR_W'(SPR_W) + col;

  logic       in_box_d1, in_box_d2;
  logic [3:0] sel_d2;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr   <= '0;
      rom_sel    <= 4'd0;
      in_box_d1  <= 1'b0;
      in_box_d2  <= 1'b0;
      sel_d2     <= 4'd0;
      pix_index  <= 4'd0;
      pix_sel    <= 4'd0;
      pix_opaque <= 1'b0;
    end else begin
      rom_addr   <= in_box ? addr : '0;
      rom_sel    <= cur_sel;
      in_box_d1  <= in_box;
      in_box_d2  <= in_box_d1;
      sel_d2     <= rom_sel;
      pix_index  <= in_box_d2 ? rom_data : 4'd0;
      pix_sel    <= sel_d2;
      pix_opaque <= in_box_d2 && (rom_data != 4'd0);
    end
  end

endmodule

// File: tb/tb_fighter_sprite_fetch.sv
// Bench for fighter_sprite_fetch: address table, hand-written pose/anim/reset sequences and
// randomized pixels against a per-cycle expectation history built from a frame-count walk model.
module tb_fighter_sprite_fetch;

  localparam int AF = 8;
  localparam int SW = 96;
  localparam int SH = 128;
  localparam int N  = 4096;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_start;
  logic [9:0]  draw_x, draw_y, fighter_x, fighter_y;
  logic [3:0]  fighter_state;
  logic        facing_left;
  logic [13:0] rom_addr;
  logic [3:0]  rom_sel, rom_data, pix_index, pix_sel;
  logic        pix_opaque;

  fighter_sprite_fetch #(.SPR_W(SW), .SPR_H(SH), .ANIM_FRAMES(AF)) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .draw_x(draw_x), .draw_y(draw_y), .fighter_x(fighter_x), .fighter_y(fighter_y),
    .fighter_state(fighter_state), .facing_left(facing_left),
    .rom_addr(rom_addr), .rom_sel(rom_sel), .rom_data(rom_data),
    .pix_index(pix_index), .pix_sel(pix_sel), .pix_opaque(pix_opaque)
  );

  always #5 Clk = ~Clk;

  int rom_mode = 0;

  function automatic logic [3:0] rom_fn(int a, int s, int m);
    if (m == 1) return 4'd5;
    if (m == 2) return 4'd0;
    return 4'((a * 7 + (a >> 5) + s * 3) & 15);
  endfunction

  always @(posedge Clk) rom_data <= rom_fn(int'(rom_addr), int'(rom_sel), rom_mode);

  int n_checks = 0;
  int n_fail   = 0;
  int t        = -1;
  int h_rst[N], h_addr[N], h_sel[N], h_idx[N], h_op[N];
  int m_pose   = 0;
  int m_walk   = 0;
  int cur_fx = 100, cur_fy = 200, cur_st = 0;
  logic cur_fl = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got %0d expected %0d", name, t, act, exp);
    end
  endtask

  // walk phase depends only on how many consecutive frames the pose has been "move"
  function automatic int model_sel();
    if (m_pose != 1) return m_pose;
    return ((((m_walk - 1) / AF) % 2) != 0) ? 9 : 1;
  endfunction

  task automatic step(logic rst, logic fs, int dx, int dy, int fx, int fy, int st, logic fl);
    int s, ib, a, sl, ix, p;
    bit z;
    @(negedge Clk);
    t++;
    if (t >= 1) begin
      s = (t - 1) % N;
      chk("rom_addr", 32'(rom_addr), h_rst[s] != 0 ? 0 : 32'(h_addr[s]));
      chk("rom_sel",  32'(rom_sel),  h_rst[s] != 0 ? 0 : 32'(h_sel[s]));
    end
    if (t >= 3) begin
      s = (t - 3) % N;
      z = (h_rst[(t-1)%N] != 0) || (h_rst[(t-2)%N] != 0) || (h_rst[s] != 0);
      chk("pix_index",  32'(pix_index),  z ? 0 : 32'(h_idx[s]));
      chk("pix_sel",    32'(pix_sel),    z ? 0 : 32'(h_sel[s]));
      chk("pix_opaque", 32'(pix_opaque), z ? 0 : 32'(h_op[s]));
    end
    Reset = rst; frame_start = fs;
    draw_x = 10'(dx); draw_y = 10'(dy); fighter_x = 10'(fx); fighter_y = 10'(fy);
    fighter_state = 4'(st); facing_left = fl;
    ib = (dx >= fx && dx < fx + SW && dy >= fy && dy < fy + SH) ? 1 : 0;
    a  = ib != 0 ? (dy - fy) * SW + (fl ? (SW - 1 - (dx - fx)) : (dx - fx)) : 0;
    sl = model_sel();
    ix = ib != 0 ? int'(rom_fn(a, sl, rom_mode)) : 0;
    s  = t % N;
    h_rst[s] = rst ? 1 : 0; h_addr[s] = a; h_sel[s] = sl; h_idx[s] = ix; h_op[s] = (ix != 0) ? 1 : 0;
    if (rst) begin
      m_pose = 0; m_walk = 0;
    end else if (fs) begin
      p = (st > 8) ? 0 : st;
      m_walk = (p == 1) ? ((m_pose == 1) ? m_walk + 1 : 1) : 0;
      m_pose = p;
    end
  endtask

  task automatic px(int dx, int dy);
    step(1'b0, 1'b0, dx, dy, cur_fx, cur_fy, cur_st, cur_fl);
  endtask

  task automatic pulse();
    step(1'b0, 1'b1, 639, 479, cur_fx, cur_fy, cur_st, cur_fl);
  endtask

  task automatic settle();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_rom(int m);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 0, 1000, 1000, cur_st, 1'b0);
    rom_mode = m;
  endtask

  typedef struct {
    int   fx, fy, dx, dy;
    logic fl;
    int   exp_addr;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{100, 200, 100, 200, 1'b0, 0};
    tbl[1]  = '{100, 200, 195, 327, 1'b0, 12287};
    tbl[2]  = '{100, 200, 100, 200, 1'b1, 95};
    tbl[3]  = '{100, 200,  99, 200, 1'b1, 0};
    tbl[4]  = '{100, 200, 196, 200, 1'b0, 0};
    tbl[5]  = '{100, 200, 100, 328, 1'b0, 0};
    tbl[6]  = '{100, 200, 100, 201, 1'b0, 96};
    tbl[7]  = '{100, 200, 195, 201, 1'b1, 96};
    tbl[8]  = '{100, 200, 150, 250, 1'b0, 4850};
    tbl[9]  = '{100, 200, 150, 250, 1'b1, 4845};
    tbl[10] = '{600,   0, 639,   0, 1'b0, 39};
    tbl[11] = '{600,   0,   0,   0, 1'b0, 0};
    tbl[12] = '{600,   0, 600, 127, 1'b1, 12287};

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b0);

    // reset mid-sprite with a non-stand pose latched
    cur_st = 6; pulse();
    for (int i = 0; i < 3; i++) px(120, 220);
    step(1'b1, 1'b0, 120, 220, cur_fx, cur_fy, cur_st, cur_fl);
    step(1'b1, 1'b0, 120, 220, cur_fx, cur_fy, cur_st, cur_fl);
    settle();
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_rom_sel", 32'(rom_sel), 0);
    chk("rst_pix_index", 32'(pix_index), 0);
    chk("rst_pix_sel", 32'(pix_sel), 0);
    chk("rst_pix_opaque", 32'(pix_opaque), 0);
    px(120, 220); settle();
    chk("rst_pose_stand", 32'(rom_sel), 0);
    cur_st = 0; pulse(); px(120, 220); settle();
    chk("pose_stand_latched", 32'(rom_sel), 0);

    for (int i = 0; i < 13; i++) begin
      step(1'b0, 1'b0, tbl[i].dx, tbl[i].dy, tbl[i].fx, tbl[i].fy, cur_st, tbl[i].fl);
      settle();
      chk("tbl_addr", 32'(rom_addr), 32'(tbl[i].exp_addr));
    end

    set_rom(1);
    cur_fx = 100; cur_fy = 200; cur_fl = 1'b0;
    px(100, 200); settle();
    chk("corner_addr", 32'(rom_addr), 0);
    px(195, 327); px(195, 327); px(195, 327); settle();
    chk("far_addr", 32'(rom_addr), 12287);
    chk("rom5_index", 32'(pix_index), 5);
    chk("rom5_sel", 32'(pix_sel), 0);
    chk("rom5_opaque", 32'(pix_opaque), 1);

    cur_fl = 1'b1;
    px(100, 200); settle();
    chk("mirror_addr", 32'(rom_addr), 95);
    px(99, 200); px(99, 200); px(99, 200); settle();
    chk("left_out_opaque", 32'(pix_opaque), 0);
    chk("left_out_index", 32'(pix_index), 0);
    cur_fl = 1'b0;

    set_rom(0);
    cur_st = 1;
    for (int k = 1; k <= 18; k++) begin
      pulse(); px(130, 230); settle();
      chk("walk_sel", 32'(rom_sel), (k <= 8 || k >= 17) ? 1 : 9);
      px(131, 231); px(132, 232);
    end
    cur_st = 5; pulse(); px(130, 230); settle();
    chk("walk_to_punch", 32'(rom_sel), 5);
    cur_st = 1; pulse(); px(130, 230); settle();
    chk("walk_restart", 32'(rom_sel), 1);

    cur_st = 3; pulse(); px(140, 240);
    cur_st = 4; px(141, 240); px(142, 240); settle();
    chk("pose_frozen", 32'(rom_sel), 3);
    pulse(); px(140, 240); settle();
    chk("pose_next_frame", 32'(rom_sel), 4);
    cur_st = 12; pulse(); px(140, 240); settle();
    chk("pose_invalid_stand", 32'(rom_sel), 0);

    set_rom(2);
    cur_st = 0; cur_fx = 600; cur_fy = 0;
    pulse();
    for (int x = 600; x < 640; x++) px(x, 5);
    for (int x = 0; x < 56; x++) px(x, 5);
    px(55, 5); settle();
    chk("nowrap_addr", 32'(rom_addr), 0);

    set_rom(0);
    for (int i = 0; i < 2500; i++) begin
      int fx, fy, dx, dy;
      logic rst, fs;
      fx  = $urandom_range(0, 700);
      fy  = $urandom_range(0, 500);
      dx  = ($urandom_range(0, 1) != 0) ? fx + $urandom_range(0, 100) - 2 : $urandom_range(0, 639);
      dy  = ($urandom_range(0, 1) != 0) ? fy + $urandom_range(0, 132) - 2 : $urandom_range(0, 479);
      if (dx < 0) dx = 0;
      if (dx > 1023) dx = 1023;
      if (dy < 0) dy = 0;
      if (dy > 1023) dy = 1023;
      fs  = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 399) == 0);
      if (fs) cur_st = ($urandom_range(0, 2) == 0) ? 1 : $urandom_range(0, 15);
      step(rst, fs, dx, dy, fx, fy, cur_st, 1'($urandom_range(0, 1)));
    end
    set_rom(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
